// File: rtl/dormir_pkg.sv
// dormir_pkg: state encodings and default timing for the pet sleep/fatigue FSM
package dormir_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_NEUTRAL = 3'd1;
  localparam logic [2:0] ST_TIRED   = 3'd2;
  localparam logic [2:0] ST_SLEEP   = 3'd3;
  localparam logic [2:0] ST_DEATH   = 3'd4;
  localparam int DEF_NEUTRAL_TIME = 5;
  localparam int DEF_TIRED_TIME   = 4;
  localparam int DEF_SLEEP_MIN    = 1;
  localparam int DEF_TICK_DIV     = 20;
  function automatic int max_of(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/dormir_tick_gen.sv
// dormir_tick_gen: prescaler emitting a one-cycle tick every TICK_DIV cycles, restartable by clr
module dormir_tick_gen #(
  parameter int TICK_DIV = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == CW'(TICK_DIV - 1);
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dormir_test.sv
// dormir_test: Tamagotchi sleep/fatigue FSM with one-hot status flags
module dormir_test import dormir_pkg::*; #(
  parameter int NEUTRAL_TIME = DEF_NEUTRAL_TIME,
  parameter int TIRED_TIME   = DEF_TIRED_TIME,
  parameter int SLEEP_MIN    = DEF_SLEEP_MIN,
  parameter int TICK_DIV     = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic botonSleep,
  input  logic botonAwake,
  input  logic botonFeed,
  output logic sign_IDLE,
  output logic sign_NEUTRAL,
  output logic sign_TIRED,
  output logic sign_SLEEP,
  output logic sign_DEATH
);
  localparam int MAX_T = max_of(max_of(NEUTRAL_TIME, TIRED_TIME), max_of(SLEEP_MIN, 1));
  localparam int TW = $clog2(MAX_T) + 1;
  logic [2:0] state_q, state_d;
  logic [TW-1:0] ticks_q, ticks_d;
  logic [TW:0] elapsed;
  logic tick, clr, unused_feed;
  assign unused_feed = botonFeed;
  dormir_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .clr(clr), .tick(tick));
  assign elapsed = {1'b0, ticks_q} + (TW+1)'(tick);
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:    state_d = elapsed >= (TW+1)'(1) ? ST_NEUTRAL : ST_IDLE;
      ST_NEUTRAL: state_d = botonSleep ? ST_SLEEP : elapsed >= (TW+1)'(NEUTRAL_TIME) ? ST_TIRED : ST_NEUTRAL;
      ST_TIRED:   state_d = botonSleep ? ST_SLEEP : elapsed >= (TW+1)'(TIRED_TIME) ? ST_DEATH : ST_TIRED;
      ST_SLEEP:   state_d = (botonAwake && !botonSleep && elapsed >= (TW+1)'(SLEEP_MIN)) ? ST_NEUTRAL : ST_SLEEP;
      ST_DEATH:   state_d = ST_DEATH;
      default:    state_d = ST_IDLE;
    endcase
  end
  assign clr = state_d != state_q;
  always_comb ticks_d = clr ? '0 : ticks_q + TW'(tick && ticks_q != '1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ticks_q <= '0;
    end else begin
      state_q <= state_d;
      ticks_q <= ticks_d;
    end
  end
  assign sign_IDLE    = state_q == ST_IDLE;
  assign sign_NEUTRAL = state_q == ST_NEUTRAL;
  assign sign_TIRED   = state_q == ST_TIRED;
  assign sign_SLEEP   = state_q == ST_SLEEP;
  assign sign_DEATH   = state_q == ST_DEATH;
endmodule

// File: tb/tb_dormir_test.sv
// tb_dormir_test: cycle-count reference model feeding a scoreboard of expected flags
module tb_dormir_test;
  localparam int NT = 5, TT = 4, SM = 1, TD = 20;
  logic clk = 0, rst = 1, bs = 0, ba = 0, bf = 0;
  logic s_i, s_n, s_t, s_s, s_d;
  logic [4:0] flags;
  logic [4:0] exp_q[$];
  int checks = 0, errors = 0;
  int m_st = 0, m_cnt = 0;
  int n;
  always #5 clk = ~clk;
  assign flags = {s_d, s_s, s_t, s_n, s_i};
  dormir_test dut (
    .clk(clk), .rst(rst), .botonSleep(bs), .botonAwake(ba), .botonFeed(bf),
    .sign_IDLE(s_i), .sign_NEUTRAL(s_n), .sign_TIRED(s_t), .sign_SLEEP(s_s), .sign_DEATH(s_d)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic model_step();
    int k, nx;
    k = m_cnt + 1;
    if (rst) begin
      m_st = 0;
      m_cnt = 0;
    end else begin
      case (m_st)
        0: nx = k >= TD ? 1 : 0;
        1: nx = bs ? 3 : (k >= NT * TD ? 2 : 1);
        2: nx = bs ? 3 : (k >= TT * TD ? 4 : 2);
        3: nx = (ba && !bs && k >= SM * TD) ? 1 : 3;
        default: nx = 4;
      endcase
      m_cnt = nx != m_st ? 0 : (k < 1000000 ? k : m_cnt);
      m_st = nx;
    end
    exp_q.push_back(5'(1 << m_st));
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("flags", {27'd0, flags}, {27'd0, exp_q.pop_front()});
  endtask
  task automatic run_until(input int bit_idx, input int bound, output int cnt);
    cnt = 0;
    while (cnt < bound) begin
      cyc();
      cnt++;
      if (flags[bit_idx]) break;
    end
  endtask
  initial begin
    for (int i = 0; i < 25; i++) begin
      bs = 1'($urandom); ba = 1'($urandom); bf = 1'($urandom);
      cyc();
      check("reset_idle", {27'd0, flags}, 32'h1);
    end
    bs = 0; ba = 0; bf = 0; rst = 0;
    run_until(1, 300, n); check("idle_len", n, 20);
    run_until(2, 300, n); check("neutral_len", n, 100);
    run_until(4, 300, n); check("tired_len", n, 80);
    repeat (10) cyc();
    check("death_stays", {31'd0, s_d}, 1);
    bs = 1; ba = 1; bf = 1;
    repeat (3) cyc();
    bf = 1'bx;
    repeat (2) cyc();
    bs = 0; ba = 0; bf = 0;
    cyc();
    check("death_buttons", {31'd0, s_d}, 1);
    rst = 1;
    cyc();
    check("reset_from_death", {27'd0, flags}, 32'h1);
    rst = 0;
    run_until(1, 300, n); check("idle_len2", n, 20);
    run_until(2, 300, n); check("neutral_len2", n, 100);
    run_until(4, 300, n); check("tired_len2", n, 80);
    rst = 1;
    cyc();
    rst = 0;
    run_until(2, 300, n); check("to_tired", n, 120);
    repeat (5) cyc();
    bs = 1;
    cyc();
    check("sleep_enter", {31'd0, s_s}, 1);
    repeat (25) cyc();
    bs = 0; ba = 1;
    cyc();
    check("awake_exit", {31'd0, s_n}, 1);
    ba = 0;
    run_until(2, 300, n); check("retired_len", n, 100);
    bs = 1;
    cyc();
    check("sleep_enter2", {31'd0, s_s}, 1);
    bs = 0;
    repeat (5) cyc();
    ba = 1;
    run_until(1, 100, n); check("sleep_min_len", n + 5, 20);
    bs = 1;
    cyc();
    check("sleep_both", {31'd0, s_s}, 1);
    for (int i = 0; i < 50; i++) begin
      bf = (i % 3 == 0) ? 1'b0 : (i % 3 == 1) ? 1'b1 : 1'bx;
      cyc();
    end
    check("sleep_held", {31'd0, s_s}, 1);
    bs = 0; bf = 1'bx;
    cyc();
    check("wake_after_hold", {31'd0, s_n}, 1);
    ba = 0;
    for (int i = 0; i < 40; i++) begin
      bf = (i % 2 == 0) ? 1'bx : 1'b1;
      cyc();
    end
    check("feed_ignored", {31'd0, s_n}, 1);
    bf = 0;
    run_until(4, 400, n); check("death_final", {31'd0, s_d}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
